// File: rtl/alu_sequencer.sv
// Two-client round-robin front end for the 4-bit ALU: latches the granted operands, steps the ALU
// through init/execute/completion and returns registered results with a one-cycle valid pulse.
module alu_sequencer #(
   parameter int INIT_CYCLES = 1,
   parameter int MUL_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic [2:0] i_op0,
   input  logic [2:0] i_op1,
   input  logic [3:0] i_a0,
   input  logic [3:0] i_b0,
   input  logic [3:0] i_a1,
   input  logic [3:0] i_b1,
   input  logic       i_cin0,
   input  logic       i_cin1,
   output logic [3:0] o_alu_a,
   output logic [3:0] o_alu_b,
   output logic [2:0] o_alu_op,
   output logic       o_alu_cin,
   output logic       o_alu_init,
   input  logic [6:0] i_alu_result,
   input  logic       i_alu_carry,
   input  logic       i_alu_overflow,
   input  logic       i_alu_done,
   output logic       o_rsp_valid0,
   output logic       o_rsp_valid1,
   output logic [6:0] o_rsp_result,
   output logic       o_rsp_carry,
   output logic       o_rsp_overflow,
   output logic       o_rsp_zero,
   output logic       o_rsp_err,
   output logic       o_busy
);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_SHL = 3'b011;
   localparam logic [2:0] OP_AND = 3'b111;
   localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int TCW = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_EXEC = 3'd2,
      S_WAIT = 3'd3,
      S_CAPT = 3'd4,
      S_RESP = 3'd5
   } state_t;

   function automatic logic op_is_valid(input logic [2:0] op);
      logic v;
      case (op)
         OP_ADD, OP_MUL, OP_SHL, OP_AND: v = 1'b1;
         default:                        v = 1'b0;
      endcase
      return v;
   endfunction

   state_t           r_state;
   state_t           w_next;
   logic             r_last_grant;
   logic             w_last_next;
   logic             r_gnt;
   logic             w_gnt;
   logic             w_take;
   logic [2:0]       w_sel_op;
   logic [3:0]       w_sel_a;
   logic [3:0]       w_sel_b;
   logic             w_sel_cin;
   logic [ICW-1:0]   r_init_cnt;
   logic [TCW-1:0]   r_to_cnt;
   logic [3:0]       r_alu_a;
   logic [3:0]       r_alu_b;
   logic [2:0]       r_alu_op;
   logic             r_alu_cin;
   logic             r_alu_init;
   logic             r_rsp_valid0;
   logic             r_rsp_valid1;
   logic [6:0]       r_rsp_result;
   logic             r_rsp_carry;
   logic             r_rsp_overflow;
   logic             r_rsp_zero;
   logic             r_rsp_err;
   logic             r_busy;

   // Arbitration and next-state decode
   always_comb begin
      w_next      = r_state;
      w_gnt       = r_gnt;
      w_take      = 1'b0;
      w_last_next = r_last_grant;
      case (r_state)
         S_IDLE: begin
            // last_grant only moves on contention, so a lone requester never steals the next tie
            if (i_req0 && i_req1) begin
               w_take      = 1'b1;
               w_gnt       = ~r_last_grant;
               w_last_next = ~r_last_grant;
            end else if (i_req0) begin
               w_take = 1'b1;
               w_gnt  = 1'b0;
            end else if (i_req1) begin
               w_take = 1'b1;
               w_gnt  = 1'b1;
            end else begin
               w_take = 1'b0;
            end
         end
         S_INIT: begin
            if (r_init_cnt == ICW'(INIT_CYCLES - 1)) begin
               w_next = S_EXEC;
            end else begin
               w_next = S_INIT;
            end
         end
         S_EXEC: begin
            if (r_alu_op == OP_MUL) begin
               w_next = S_WAIT;
            end else begin
               w_next = S_CAPT;
            end
         end
         S_WAIT: begin
            if (i_alu_done) begin
               w_next = S_CAPT;
            end else if (r_to_cnt == TCW'(MUL_TIMEOUT - 1)) begin
               w_next = S_RESP;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_CAPT:  w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase

      w_sel_op  = w_gnt ? i_op1  : i_op0;
      w_sel_a   = w_gnt ? i_a1   : i_a0;
      w_sel_b   = w_gnt ? i_b1   : i_b0;
      w_sel_cin = w_gnt ? i_cin1 : i_cin0;
      if (r_state == S_IDLE) begin
         if (w_take) begin
            w_next = op_is_valid(w_sel_op) ? S_INIT : S_RESP;
         end else begin
            w_next = S_IDLE;
         end
      end else begin
         w_sel_cin = w_sel_cin;
      end
   end

   // State, grant bookkeeping, counters and ALU drive registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_gnt        <= 1'b0;
         r_init_cnt   <= '0;
         r_to_cnt     <= '0;
         r_alu_a      <= 4'd0;
         r_alu_b      <= 4'd0;
         r_alu_op     <= 3'd0;
         r_alu_cin    <= 1'b0;
         r_alu_init   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_last_grant <= w_last_next;
         r_gnt        <= w_gnt;
         r_alu_init   <= (w_next == S_INIT);
         r_busy       <= (w_next != S_IDLE);
         r_init_cnt   <= (r_state == S_INIT) ? r_init_cnt + 1'b1 : '0;
         r_to_cnt     <= (r_state == S_WAIT) ? r_to_cnt + 1'b1 : '0;
         // Invalid ops bypass the ALU entirely, so its inputs keep their previous values
         if (r_state == S_IDLE && w_take && op_is_valid(w_sel_op)) begin
            r_alu_a   <= w_sel_a;
            r_alu_b   <= w_sel_b;
            r_alu_op  <= w_sel_op;
            r_alu_cin <= w_sel_cin;
         end
      end
   end

   // Response capture and completion pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid0   <= 1'b0;
         r_rsp_valid1   <= 1'b0;
         r_rsp_result   <= 7'd0;
         r_rsp_carry    <= 1'b0;
         r_rsp_overflow <= 1'b0;
         r_rsp_zero     <= 1'b0;
         r_rsp_err      <= 1'b0;
      end else begin
         r_rsp_valid0 <= (w_next == S_RESP) && !w_gnt;
         r_rsp_valid1 <= (w_next == S_RESP) && w_gnt;
         if (w_next == S_RESP) begin
            if (r_state == S_CAPT) begin
               r_rsp_result   <= i_alu_result;
               r_rsp_carry    <= (r_alu_op == OP_ADD) ? i_alu_carry : 1'b0;
               r_rsp_overflow <= (r_alu_op == OP_MUL) ? i_alu_overflow : 1'b0;
               r_rsp_zero     <= (i_alu_result == 7'd0);
               r_rsp_err      <= 1'b0;
            end else begin
               r_rsp_result   <= 7'd0;
               r_rsp_carry    <= 1'b0;
               r_rsp_overflow <= 1'b0;
               r_rsp_zero     <= 1'b0;
               r_rsp_err      <= 1'b1;
            end
         end
      end
   end

   assign o_alu_a        = r_alu_a;
   assign o_alu_b        = r_alu_b;
   assign o_alu_op       = r_alu_op;
   assign o_alu_cin      = r_alu_cin;
   assign o_alu_init     = r_alu_init;
   assign o_rsp_valid0   = r_rsp_valid0;
   assign o_rsp_valid1   = r_rsp_valid1;
   assign o_rsp_result   = r_rsp_result;
   assign o_rsp_carry    = r_rsp_carry;
   assign o_rsp_overflow = r_rsp_overflow;
   assign o_rsp_zero     = r_rsp_zero;
   assign o_rsp_err      = r_rsp_err;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a small behavioural ALU feeds the sequencer and every
// comparison is an immediate assertion against hand-computed values.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, cin0, cin1;
   logic [2:0] op0, op1;
   logic [3:0] a0, b0, a1, b1;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_op;
   logic       alu_cin, alu_init;
   logic [6:0] alu_result;
   logic       alu_carry, alu_overflow, alu_done;
   logic       rsp_valid0, rsp_valid1;
   logic [6:0] rsp_result;
   logic       rsp_carry, rsp_overflow, rsp_zero, rsp_err, busy;
   logic [6:0] tb_mul_res;
   logic       tb_mul_ovf, tb_done;
   logic [4:0] sum5;
   int         n_vec = 0;
   int         n_err = 0;
   int         n;
   int         who;

   always #5 clk = ~clk;

   alu_sequencer #(.INIT_CYCLES(1), .MUL_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req0(req0), .i_req1(req1), .i_op0(op0), .i_op1(op1),
      .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1), .i_cin0(cin0), .i_cin1(cin1),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_alu_cin(alu_cin),
      .o_alu_init(alu_init), .i_alu_result(alu_result), .i_alu_carry(alu_carry),
      .i_alu_overflow(alu_overflow), .i_alu_done(alu_done),
      .o_rsp_valid0(rsp_valid0), .o_rsp_valid1(rsp_valid1), .o_rsp_result(rsp_result),
      .o_rsp_carry(rsp_carry), .o_rsp_overflow(rsp_overflow), .o_rsp_zero(rsp_zero),
      .o_rsp_err(rsp_err), .o_busy(busy)
   );

   // Behavioural ALU; carry/overflow idle high so masking in the sequencer is visible
   always_comb begin
      alu_result   = 7'd0;
      alu_carry    = 1'b1;
      alu_overflow = 1'b1;
      alu_done     = tb_done;
      sum5         = 5'd0;
      case (alu_op)
         3'b001: begin
            sum5       = {1'b0, alu_a} + {1'b0, (alu_cin ? ~alu_b : alu_b)} + {4'd0, alu_cin};
            alu_result = {3'b000, sum5[3:0]};
            alu_carry  = sum5[4];
         end
         3'b010: begin
            alu_result   = tb_mul_res;
            alu_overflow = tb_mul_ovf;
         end
         3'b011:  alu_result = {3'b000, alu_a} << alu_b[1:0];
         3'b111:  alu_result = {3'b000, alu_a & alu_b};
         default: alu_result = 7'd0;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_until(input int which, input int bound, output int cnt);
      cnt = 0;
      while (cnt < bound) begin
         tick();
         cnt++;
         if ((which == 0) ? rsp_valid0 : rsp_valid1) break;
      end
   endtask

   task automatic run_any(input int bound, output int cnt, output int id);
      cnt = 0;
      id  = -1;
      while (cnt < bound) begin
         tick();
         cnt++;
         if (rsp_valid0) begin id = 0; break; end
         if (rsp_valid1) begin id = 1; break; end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; op0 = 3'd0; op1 = 3'd0;
      a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0; cin0 = 1'b0; cin1 = 1'b0;
      tb_mul_res = 7'd0; tb_mul_ovf = 1'b0; tb_done = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_init", 32'(alu_init), 32'd0);
      chk("rst_valid", 32'({rsp_valid1, rsp_valid0}), 32'd0);
      chk("rst_rsp", 32'({rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_err}), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b, alu_op, alu_cin}), 32'd0);
      rst_n = 1'b1;

      // add 5+6 from client 0; operands changed after grant must not matter
      req0 = 1'b1; op0 = 3'b001; a0 = 4'd5; b0 = 4'd6; cin0 = 1'b0;
      tick();
      chk("add_init", 32'(alu_init), 32'd1);
      chk("add_busy", 32'(busy), 32'd1);
      chk("add_alu_a", 32'(alu_a), 32'd5);
      a0 = 4'd0; b0 = 4'd0;
      run_until(0, 40, n);
      chk("add_latency", 32'(n + 1), 32'd4);
      chk("add_result", 32'(rsp_result), 32'd11);
      chk("add_flags", 32'({rsp_carry, rsp_overflow, rsp_zero, rsp_err}), 32'd0);
      chk("add_valid1", 32'(rsp_valid1), 32'd0);
      req0 = 1'b0;
      tick();
      chk("add_pulse_end", 32'(rsp_valid0), 32'd0);
      chk("add_hold", 32'(rsp_result), 32'd11);
      chk("add_idle", 32'(busy), 32'd0);

      // both clients held with AND ops: grants alternate 0,1,0,1
      req0 = 1'b1; op0 = 3'b111; a0 = 4'hF; b0 = 4'h3; cin0 = 1'b0;
      req1 = 1'b1; op1 = 3'b111; a1 = 4'hC; b1 = 4'h3; cin1 = 1'b0;
      for (int g = 0; g < 4; g++) begin
         run_any(40, n, who);
         chk("and_grant", 32'(who), 32'(g % 2));
         chk("and_latency", 32'(n), (g == 0) ? 32'd4 : 32'd5);
         chk("and_result", 32'(rsp_result), (g % 2 == 0) ? 32'd3 : 32'd0);
         chk("and_zero", 32'(rsp_zero), (g % 2 == 0) ? 32'd0 : 32'd1);
         chk("and_flags", 32'({rsp_carry, rsp_overflow, rsp_err}), 32'd0);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();

      // invalid op: answered next cycle, ALU never started
      req0 = 1'b1; op0 = 3'b100; a0 = 4'd7; b0 = 4'd7;
      tick();
      chk("inv_valid", 32'(rsp_valid0), 32'd1);
      chk("inv_err", 32'(rsp_err), 32'd1);
      chk("inv_rsp", 32'({rsp_result, rsp_carry, rsp_overflow, rsp_zero}), 32'd0);
      chk("inv_no_init", 32'(alu_init), 32'd0);
      req0 = 1'b0;
      tick();
      chk("inv_pulse_end", 32'({rsp_valid0, busy}), 32'd0);

      // multiply on client 1, done raised in the sixth WAIT_DONE cycle
      req1 = 1'b1; op1 = 3'b010; a1 = 4'hF; b1 = 4'hF; cin1 = 1'b0;
      tb_mul_res = 7'h61; tb_mul_ovf = 1'b1;
      tick();
      chk("mul_init", 32'({alu_init, alu_op, alu_a}), 32'({1'b1, 3'b010, 4'hF}));
      tick();
      chk("mul_exec", 32'(alu_init), 32'd0);
      repeat (6) tick();
      chk("mul_wait", 32'({busy, rsp_valid1}), 32'b10);
      tb_done = 1'b1;
      tick();
      tb_done = 1'b0;
      chk("mul_capt", 32'(rsp_valid1), 32'd0);
      tick();
      chk("mul_valid", 32'(rsp_valid1), 32'd1);
      chk("mul_result", 32'(rsp_result), 32'h61);
      chk("mul_flags", 32'({rsp_carry, rsp_overflow, rsp_zero, rsp_err}), 32'b0100);
      req1 = 1'b0;
      tick();

      // multiply with no done: timeout 16 cycles after entering WAIT_DONE (cycle 3)
      req0 = 1'b1; op0 = 3'b010; a0 = 4'd3; b0 = 4'd2;
      run_until(0, 60, n);
      chk("to_latency", 32'(n), 32'd19);
      chk("to_err", 32'(rsp_err), 32'd1);
      chk("to_rsp", 32'({rsp_result, rsp_carry, rsp_overflow, rsp_zero}), 32'd0);
      req0 = 1'b0;
      tick();

      // asynchronous reset while waiting on a multiply
      req1 = 1'b1; op1 = 3'b010; a1 = 4'd2; b1 = 4'd2;
      repeat (4) tick();
      chk("ar_pre_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_rsp", 32'({rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_err}), 32'd0);
      chk("ar_alu", 32'({alu_a, alu_b, alu_op, alu_cin, alu_init}), 32'd0);
      op1 = 3'b001; a1 = 4'd9; b1 = 4'd4; cin1 = 1'b1;
      tick();
      tick();
      chk("ar_no_valid", 32'({rsp_valid0, rsp_valid1}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("ar_grant1", 32'({busy, alu_a}), 32'({1'b1, 4'd9}));
      req0 = 1'b1; op0 = 3'b011; a0 = 4'd3; b0 = 4'd2; cin0 = 1'b0;
      run_until(1, 40, n);
      chk("sub_latency", 32'(n + 1), 32'd4);
      chk("sub_result", 32'(rsp_result), 32'd5);
      chk("sub_carry", 32'({rsp_carry, rsp_overflow, rsp_zero, rsp_err}), 32'b1000);
      req1 = 1'b0;
      run_until(0, 40, n);
      chk("shl_latency", 32'(n), 32'd5);
      chk("shl_result", 32'(rsp_result), 32'd12);
      chk("shl_flags", 32'({rsp_carry, rsp_overflow, rsp_zero, rsp_err}), 32'd0);
      req0 = 1'b0;
      tick();
      chk("end_idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
